// File: rtl/freq_estimator_pkg.sv
// rtl/freq_estimator_pkg.sv - shared state encoding and divider timing constants
package freq_estimator_pkg;

  // Measurement controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DIVIDE  = 2'd2
  } fe_state_e;

  // Cycles from the closing crossing to freq_valid when K = 0; each extra
  // bit of averaging (K) adds one quotient bit and so one divider step.
  localparam int DIV_LATENCY_BASE = 34;

  // Quotient bits (and divider iterations) for a given K: 2^(32+K) needs 33+K bits.
  function automatic int div_steps(input int k);
    return DIV_LATENCY_BASE - 1 + k;
  endfunction

endpackage

// File: rtl/recip_divider.sv
// rtl/recip_divider.sv - sequential restoring divide of 2^(32+K) by a 32-bit divisor
module recip_divider
  import freq_estimator_pkg::*;
#(
  parameter int K = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient
);

  localparam int DW = div_steps(K);

  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_iter;
  logic [31:0]   r_div;
  logic [31:0]   r_rem;
  logic [DW-1:0] r_dvd;
  logic [DW-1:0] r_quot;

  logic [32:0]   w_shift;
  logic [32:0]   w_diff;
  logic          w_ge;
  logic [31:0]   w_rem_next;
  logic          w_sat;

  // One restoring step: the partial remainder always stays below the divisor,
  // so after the subtract-or-keep decision it fits back into 32 bits.
  assign w_shift    = {r_rem, r_dvd[DW-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_rem_next = w_ge ? w_diff[31:0] : w_shift[31:0];

  // Anything that needs more than 32 bits clamps to the largest tuning word
  assign w_sat      = |r_quot[DW-1:32];
  assign o_quotient = w_sat ? 32'hFFFF_FFFF : r_quot[31:0];
  assign o_done     = r_done;

  // Load on start, then one quotient bit per cycle, MSB first; done pulses with the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_iter <= 8'd0;
      r_div  <= 32'd0;
      r_rem  <= 32'd0;
      r_dvd  <= '0;
      r_quot <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_iter <= 8'(DW);
        r_div  <= i_divisor;
        r_rem  <= 32'd0;
        r_dvd  <= {1'b1, {(DW-1){1'b0}}};
        r_quot <= '0;
      end else if (r_busy) begin
        r_rem  <= w_rem_next;
        r_dvd  <= {r_dvd[DW-2:0], 1'b0};
        r_quot <= {r_quot[DW-2:0], w_ge};
        r_iter <= r_iter - 8'd1;
        if (r_iter == 8'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/freq_estimator.sv
// rtl/freq_estimator.sv - zero-crossing frequency estimator producing an NCO tuning word
module freq_estimator
  import freq_estimator_pkg::*;
#(
  parameter int WAVE_WIDTH      = 16,
  parameter int NUM_PERIODS     = 4,
  parameter int TIMEOUT_SAMPLES = 2**24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [WAVE_WIDTH-1:0] sample_in,
  input  logic                         sample_valid,
  input  logic        [WAVE_WIDTH-2:0] hysteresis,
  output logic        [31:0]           freq_out,
  output logic        [31:0]           period_out,
  output logic                         freq_valid,
  output logic                         locked,
  output logic                         timeout
);

  localparam int          K           = $clog2(NUM_PERIODS);
  localparam logic [31:0] LAST_CROSS  = 32'(NUM_PERIODS - 1);
  localparam logic [31:0] TIMEOUT_CNT = 32'(TIMEOUT_SAMPLES);

  fe_state_e r_state;
  fe_state_e w_state_next;

  logic        r_pol;
  logic [31:0] r_cnt;
  logic [31:0] r_cross;
  logic [31:0] r_period;
  logic [31:0] r_freq;
  logic        r_fv;
  logic        r_locked;
  logic        r_timeout;

  logic signed [WAVE_WIDTH:0] w_samp_ext;
  logic signed [WAVE_WIDTH:0] w_hyst_pos;
  logic signed [WAVE_WIDTH:0] w_hyst_neg;
  logic        w_above;
  logic        w_below;
  logic        w_rise;
  logic [31:0] w_cnt_inc;

  logic        w_clr_cnt;
  logic        w_inc_cnt;
  logic        w_inc_cross;
  logic        w_latch_period;
  logic        w_div_start;
  logic        w_timeout;
  logic        w_finish;
  logic        w_div_done;
  logic [31:0] w_div_quot;

  // Threshold compare one bit wider so that -hysteresis never overflows
  assign w_samp_ext = {sample_in[WAVE_WIDTH-1], sample_in};
  assign w_hyst_pos = {2'b00, hysteresis};
  assign w_hyst_neg = -w_hyst_pos;
  assign w_above    = (w_samp_ext > w_hyst_pos);
  assign w_below    = (w_samp_ext < w_hyst_neg);
  assign w_rise     = sample_valid & ~r_pol & w_above;
  assign w_cnt_inc  = r_cnt + 32'd1;

  // Polarity flag with hysteresis; it keeps tracking in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pol <= 1'b1;
    end else if (sample_valid) begin
      if (w_below) begin
        r_pol <= 1'b0;
      end else if (w_above) begin
        r_pol <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt      = 1'b0;
    w_inc_cnt      = 1'b0;
    w_inc_cross    = 1'b0;
    w_latch_period = 1'b0;
    w_div_start    = 1'b0;
    w_timeout      = 1'b0;
    w_finish       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_clr_cnt    = 1'b1;
          w_state_next = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (sample_valid) begin
          // A closing crossing wins over a timeout landing on the same sample
          if (w_rise && (r_cross == LAST_CROSS)) begin
            w_latch_period = 1'b1;
            w_div_start    = 1'b1;
            w_state_next   = ST_DIVIDE;
          end else if (w_cnt_inc == TIMEOUT_CNT) begin
            w_timeout    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_inc_cnt   = 1'b1;
            w_inc_cross = w_rise;
          end
        end
      end
      ST_DIVIDE: begin
        if (w_div_done) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Sample and crossing counters for the current window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 32'd0;
      r_cross <= 32'd0;
    end else if (w_clr_cnt) begin
      r_cnt   <= 32'd0;
      r_cross <= 32'd0;
    end else if (w_inc_cnt) begin
      r_cnt <= w_cnt_inc;
      if (w_inc_cross) begin
        r_cross <= r_cross + 32'd1;
      end
    end
  end

  // Result registers, status flag and one-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period  <= 32'd0;
      r_freq    <= 32'd0;
      r_fv      <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_fv      <= w_finish;
      r_timeout <= w_timeout;
      if (w_latch_period) begin
        r_period <= w_cnt_inc;
      end
      if (w_finish) begin
        r_freq   <= w_div_quot;
        r_locked <= 1'b1;
      end else if (w_timeout) begin
        r_locked <= 1'b0;
      end
    end
  end

  recip_divider #(
    .K(K)
  ) u_recip_divider (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_div_start),
    .i_divisor (w_cnt_inc),
    .o_done    (w_div_done),
    .o_quotient(w_div_quot)
  );

  assign freq_out   = r_freq;
  assign period_out = r_period;
  assign freq_valid = r_fv;
  assign locked     = r_locked;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_freq_estimator.sv
// tb/tb_freq_estimator.sv - randomized self-checking bench for freq_estimator
module tb_freq_estimator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic        [14:0] hysteresis = 15'd256;
  logic        [31:0] freq_out;
  logic        [31:0] period_out;
  logic               freq_valid;
  logic               locked;
  logic               timeout;

  logic               d_start = 1'b0;
  logic        [31:0] d_div = 32'd1;
  logic               d_done;
  logic        [31:0] d_quot;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  int fv_count = 0, fv_cyc = 0;
  int to_count = 0, to_cyc = 0;
  int dn_count = 0, dn_cyc = 0;

  // stimulus generator settings
  int wkind, wper, wamp, wnoise, wnlen, vmode, wn;

  // reference model state (accepted-sample view of the spec rules)
  bit m_pol;
  int m_state, m_cnt, m_cr, m_close_cyc, m_period;

  freq_estimator #(
    .WAVE_WIDTH     (16),
    .NUM_PERIODS    (4),
    .TIMEOUT_SAMPLES(1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .hysteresis  (hysteresis),
    .freq_out    (freq_out),
    .period_out  (period_out),
    .freq_valid  (freq_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  recip_divider #(.K(2)) u_div (
    .clk       (clk),
    .rst       (rst),
    .i_start   (d_start),
    .i_divisor (d_div),
    .o_done    (d_done),
    .o_quotient(d_quot)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (freq_valid === 1'b1) begin fv_count++; fv_cyc = cyc; end
    if (timeout === 1'b1) begin to_count++; to_cyc = cyc; end
    if (d_done === 1'b1) begin dn_count++; dn_cyc = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_freq(input longint unsigned p);
    longint unsigned q;
    q = (64'd1 << 34) / p;
    if (q > 64'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return q[31:0];
  endfunction

  function automatic logic signed [15:0] wave_at(input int n);
    int v, ph, half;
    if (wkind == 0) begin
      v = int'(real'(wamp) * $sin(2.0 * 3.141592653589793 * real'(n) / real'(wper)));
    end else begin
      ph = n % wper;
      half = wper / 2;
      if (ph < half) v = (ph < wnlen) ? int'($urandom_range(0, 2*wnoise)) - wnoise : wamp;
      else v = ((ph - half) < wnlen) ? int'($urandom_range(0, 2*wnoise)) - wnoise : -wamp;
    end
    return 16'(v);
  endfunction

  task automatic model_accept(input int s);
    bit rise;
    int h;
    h = int'(hysteresis);
    rise = !m_pol && (s > h);
    if (s < -h) m_pol = 1'b0;
    else if (s > h) m_pol = 1'b1;
    if (m_state == 0) begin
      if (rise) begin m_state = 1; m_cnt = 0; m_cr = 0; end
    end else if (m_state == 1) begin
      m_cnt++;
      if (rise) begin
        m_cr++;
        if (m_cr == 4) begin m_state = 2; m_close_cyc = cyc + 1; m_period = m_cnt; end
      end
    end
  endtask

  task automatic send(input logic signed [15:0] s);
    @(negedge clk);
    sample_in = s;
    sample_valid = 1'b1;
    model_accept(int'(s));
  endtask

  task automatic idle();
    @(negedge clk);
    sample_valid = 1'b0;
    sample_in = 16'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_pol = 1'b1;
    m_state = 0;
    wn = 0;
  endtask

  task automatic play(input int budget, input bit stop_close, output bit got);
    int fv0;
    bit v;
    fv0 = fv_count;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (i % 2 == 0);
        default: v = ($urandom_range(0, 9) < 7);
      endcase
      if (v) begin send(wave_at(wn)); wn++; end
      else idle();
      got = stop_close ? (m_state == 2) : (fv_count != fv0);
    end
    if (!stop_close) idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (freq_out !== 32'd0) begin n_fail++; $display("FAIL reset_freq: got %h want 0", freq_out); end
    n_checks++; if (period_out !== 32'd0) begin n_fail++; $display("FAIL reset_period: got %h want 0", period_out); end
    n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", freq_valid); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_sine(input int vm);
    bit got;
    int fv0;
    do_reset();
    hysteresis = 15'd256;
    wkind = 0; wper = 64; wamp = 32767; vmode = vm;
    fv0 = fv_count;
    play(2000, 1'b0, got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL sine%0d_fv: got none want pulse", vm); end
    n_checks++; if (period_out !== 32'd256) begin n_fail++; $display("FAIL sine%0d_period: got %0d want 256", vm, period_out); end
    n_checks++; if (freq_out !== 32'h0400_0000) begin n_fail++; $display("FAIL sine%0d_freq: got %h want 04000000", vm, freq_out); end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sine%0d_locked: got %b want 1", vm, locked); end
    n_checks++; if (fv_cyc - m_close_cyc != 36) begin n_fail++; $display("FAIL sine%0d_latency: got %0d want 36", vm, fv_cyc - m_close_cyc); end
    n_checks++; if (freq_valid !== 1'b0 || fv_count - fv0 != 1) begin n_fail++; $display("FAIL sine%0d_pulse: got fv=%b count=%0d want 0 and 1", vm, freq_valid, fv_count - fv0); end
  endtask

  task automatic test_noise();
    bit got;
    do_reset();
    hysteresis = 15'd80;
    wkind = 1; wper = 40; wamp = 100; wnoise = 50; wnlen = 4; vmode = 0;
    play(2000, 1'b0, got);
    n_checks++; if (!got || period_out !== 32'd160) begin n_fail++; $display("FAIL noise_period: got %0d want 160", period_out); end
    n_checks++; if (freq_out !== exp_freq(160)) begin n_fail++; $display("FAIL noise_freq: got %h want %h", freq_out, exp_freq(160)); end
  endtask

  task automatic test_period2();
    bit got;
    do_reset();
    hysteresis = 15'd256;
    wkind = 1; wper = 2; wamp = 1000; wnoise = 0; wnlen = 0; vmode = 0;
    play(500, 1'b0, got);
    n_checks++; if (!got || period_out !== 32'd8) begin n_fail++; $display("FAIL p2_period: got %0d want 8", period_out); end
    n_checks++; if (freq_out !== 32'h8000_0000) begin n_fail++; $display("FAIL p2_freq: got %h want 80000000", freq_out); end
  endtask

  task automatic test_timeout();
    int fv0, to0, t_exp;
    do_reset();
    hysteresis = 15'd256;
    fv0 = fv_count; to0 = to_count;
    repeat (1100) send(16'sd1000);
    idle();
    n_checks++; if (fv_count != fv0 || to_count != to0 || locked !== 1'b0) begin n_fail++; $display("FAIL const_quiet: got fv=%0d to=%0d locked=%b want 0 0 0", fv_count - fv0, to_count - to0, locked); end
    send(-16'sd1000); send(16'sd1000);
    repeat (4) begin send(-16'sd1000); send(16'sd1000); end
    repeat (45) send(16'sd2000);
    n_checks++; if (locked !== 1'b1 || period_out !== 32'd8) begin n_fail++; $display("FAIL to_prelock: got locked=%b period=%0d want 1 8", locked, period_out); end
    fv0 = fv_count;
    send(-16'sd1000); send(16'sd2000);
    t_exp = 0;
    for (int i = 1; i <= 1024; i++) begin
      send(16'sd2000);
      if (i == 1023 && to_count != to0) begin n_checks++; n_fail++; $display("FAIL to_early: got pulse want none before 1024"); end
      if (i == 1024) t_exp = cyc + 1;
    end
    repeat (3) idle();
    n_checks++; if (to_count - to0 != 1 || to_cyc != t_exp) begin n_fail++; $display("FAIL to_pulse: got count=%0d cyc=%0d want 1 %0d", to_count - to0, to_cyc, t_exp); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL to_locked: got %b want 0", locked); end
    n_checks++; if (freq_out !== 32'h8000_0000 || fv_count != fv0) begin n_fail++; $display("FAIL to_hold: got freq=%h fv=%0d want 80000000 0", freq_out, fv_count - fv0); end
  endtask

  task automatic test_random();
    bit got;
    int h;
    for (int it = 0; it < 5; it++) begin
      do_reset();
      h = $urandom_range(0, 2000);
      hysteresis = 15'(h);
      wkind = 1; wper = $urandom_range(4, 120); wamp = $urandom_range(h + 1, 30000);
      wnoise = h; wnlen = $urandom_range(0, wper / 2 - 1); vmode = 2;
      play(3000, 1'b0, got);
      n_checks++; if (!got || period_out !== 32'(4 * wper) || m_period != 4 * wper) begin n_fail++; $display("FAIL rand%0d_period: got %0d model %0d want %0d", it, period_out, m_period, 4 * wper); end
      n_checks++; if (freq_out !== exp_freq(longint'(4 * wper))) begin n_fail++; $display("FAIL rand%0d_freq: got %h want %h", it, freq_out, exp_freq(longint'(4 * wper))); end
      n_checks++; if (fv_cyc - m_close_cyc != 36) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 36", it, fv_cyc - m_close_cyc); end
    end
  endtask

  task automatic test_divider();
    logic [31:0] dv [7];
    int dn0, st;
    dv[0] = 32'd1; dv[1] = 32'd3; dv[2] = 32'd4; dv[3] = 32'd5;
    dv[4] = $urandom | 32'd8; dv[5] = $urandom_range(5, 5000); dv[6] = 32'hFFFF_FFFF;
    for (int i = 0; i < 7; i++) begin
      dn0 = dn_count;
      @(negedge clk); d_start = 1'b1; d_div = dv[i]; st = cyc + 1;
      @(negedge clk); d_start = 1'b0;
      for (int w = 0; w < 60 && dn_count == dn0; w++) @(negedge clk);
      n_checks++; if (dn_count == dn0 || d_quot !== exp_freq(longint'(dv[i]))) begin n_fail++; $display("FAIL div_%0d: got %h want %h", dv[i], d_quot, exp_freq(longint'(dv[i]))); end
      n_checks++; if (dn_cyc - st != 35) begin n_fail++; $display("FAIL div_latency: got %0d want 35", dn_cyc - st); end
    end
  endtask

  task automatic test_reset_divide();
    bit got;
    int fv0;
    do_reset();
    hysteresis = 15'd256;
    wkind = 0; wper = 64; wamp = 32767; vmode = 0;
    play(2000, 1'b0, got);
    m_state = 0;
    play(2000, 1'b1, got);
    repeat (10) idle();
    fv0 = fv_count;
    @(negedge clk); rst = 1'b1;
    #1;
    n_checks++; if (freq_out !== 32'd0 || period_out !== 32'd0) begin n_fail++; $display("FAIL rstdiv_out: got freq=%h period=%0d want 0 0", freq_out, period_out); end
    n_checks++; if (locked !== 1'b0 || freq_valid !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rstdiv_flags: got %b%b%b want 000", locked, freq_valid, timeout); end
    @(negedge clk); rst = 1'b0;
    m_pol = 1'b1; m_state = 0; wn = 0;
    repeat (60) idle();
    n_checks++; if (fv_count != fv0) begin n_fail++; $display("FAIL rstdiv_nofv: got %0d pulses want 0", fv_count - fv0); end
    play(2000, 1'b0, got);
    n_checks++; if (!got || period_out !== 32'd256 || freq_out !== 32'h0400_0000) begin n_fail++; $display("FAIL rstdiv_next: got %0d %h want 256 04000000", period_out, freq_out); end
  endtask

  initial begin
    test_reset();
    test_sine(0);
    test_sine(1);
    test_noise();
    test_period2();
    test_timeout();
    test_random();
    test_divider();
    test_reset_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_estimator.md
FREQ_ESTIMATOR -- requirements
Module: freq_estimator

Interface
REQ-001 Parameter WAVE_WIDTH, default 16: signed sample width.
REQ-002 Parameter NUM_PERIODS, default 4: rising crossings per measurement window; power of two; K = log2(NUM_PERIODS).
REQ-003 Parameter TIMEOUT_SAMPLES, default 2**24: maximum window length in accepted samples.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port sample_in  input  WAVE_WIDTH: signed sine sample, e.g. from the team's NCO sine output.
REQ-007 Port sample_valid  input  1: sample_in is accepted on any cycle this is high.
REQ-008 Port hysteresis  input  WAVE_WIDTH-1: unsigned crossing threshold magnitude.
REQ-009 Port freq_out  output  32: NCO-compatible tuning word, i.e. 2^32 / period-in-samples.
REQ-010 Port period_out  output  32: accepted-sample count of the last completed window.
REQ-011 Port freq_valid  output  1: one-cycle pulse when freq_out/period_out update.
REQ-012 Port locked  output  1: a valid estimate exists and no timeout has occurred since.
REQ-013 Port timeout  output  1: one-cycle pulse when a window is abandoned.

Function
REQ-014 Polarity flag: cleared (negative) when an accepted sample < -hysteresis; set (positive) when an accepted sample > +hysteresis; otherwise held; comparisons are signed and made at WAVE_WIDTH+1 bits.
REQ-015 A rising crossing is an accepted sample that sets the polarity flag while it is clear.
REQ-016 States IDLE, MEASURE, DIVIDE; reset enters IDLE.
REQ-017 IDLE: on a rising crossing, clear sample counter and crossing counter, go to MEASURE.
REQ-018 MEASURE: count every accepted sample after the starting crossing, including the window-ending crossing sample.
REQ-019 MEASURE: on the NUM_PERIODS-th rising crossing, latch count into period_out, start divider, go to DIVIDE.
REQ-020 MEASURE: if the count reaches TIMEOUT_SAMPLES before the window closes, pulse timeout, clear locked, go to IDLE; no output update.
REQ-021 DIVIDE: samples still update the polarity flag; crossings are ignored; the counters are frozen.
REQ-022 Divider computes floor(2^(32+K) / period_out); if the quotient is >= 2^32, freq_out saturates to 32'hFFFFFFFF.
REQ-023 Divider latency is fixed: freq_valid pulses exactly 34+K clk cycles after the cycle in which the closing crossing sample is accepted.
REQ-024 In that same cycle freq_out updates and locked sets; FSM returns to IDLE the next cycle.
REQ-025 freq_out and period_out hold their values between updates.
REQ-026 Counter width is 32 bits; TIMEOUT_SAMPLES < 2^32 guarantees no wrap.
REQ-027 A sample_valid gap of any length pauses counting without aborting the window.

Reset
REQ-028 Reset values: freq_out 0, period_out 0, freq_valid 0, locked 0, timeout 0, polarity flag set (positive), counters 0, state IDLE.
REQ-029 Reset asserted mid-window or mid-divide aborts immediately; no freq_valid follows deassertion.
REQ-030 Because the polarity flag resets positive, the first crossing requires a preceding sample below -hysteresis.

Structure
REQ-031 State encoding and the divider latency constant belong in the shared DSP package.
REQ-032 A single sub-module, recip_divider, implements the sequential 1-bit-per-cycle restoring divide with start/done handshake.

Verification
REQ-033 Sine with period 64 samples, amplitude 32767, hysteresis 256, sample_valid always high -> period_out 256, freq_out 32'h04000000, locked 1.
REQ-034 Same sine with sample_valid high every other cycle -> identical period_out 256 and freq_out 32'h04000000.
REQ-035 Constant input 1000 after reset, TIMEOUT_SAMPLES 1024 -> no freq_valid, locked stays 0; a ramp crossing once then stalling -> timeout pulse after 1024 accepted samples.
REQ-036 Square wave +/-100 with noise bursts of +/-50 around zero, hysteresis 80 -> no extra crossings; period estimate matches the square-wave period.
REQ-037 Period 2 square wave +/-1000, NUM_PERIODS 4 -> period_out 8, freq_out 32'h80000000; a forced period_out of 1 via direct divider test -> 32'hFFFFFFFF.
REQ-038 Reset asserted during DIVIDE -> no freq_valid, all outputs at reset values, next window measures correctly.
